// File: rtl/conv_sa_pkg.sv
// ============================================================================
// Module      : conv_sa_pkg
// Description : Shared constants and FSM encoding for the systolic-array
//               partial-sum sequencer and its sum-unit consumers.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package conv_sa_pkg;

  localparam int SLOT_AW    = 3;
  localparam int N_SLOT_MAX = 2 ** SLOT_AW;
  // Prefetch-to-write latency of every psum sum unit.
  localparam int PF2WR_LAT  = 2;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/conv_sa_psum_seq_if.sv
// ============================================================================
// Module      : conv_sa_psum_seq_if
// Description : Control/flag bundle between the psum sequencer and the host,
//               operand feeder and sum units.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface conv_sa_psum_seq_if #(
  parameter int SLOT_AW = 3,
  parameter int RND_W   = 16
);

  logic               start;
  logic [SLOT_AW:0]   cfg_n_slot;
  logic [RND_W-1:0]   cfg_n_rnd;
  logic               src_rdy;
  logic               issue;
  logic               busy;
  logic               done;
  logic [SLOT_AW-1:0] psum_prefetch_addr;
  logic               psum_vld;
  logic               psum_last_rnd;
  logic [SLOT_AW-1:0] psum_wr_addr;

  modport master (
    input  start, cfg_n_slot, cfg_n_rnd, src_rdy,
    output issue, busy, done, psum_prefetch_addr, psum_vld, psum_last_rnd, psum_wr_addr
  );

  modport slave (
    output start, cfg_n_slot, cfg_n_rnd, src_rdy,
    input  issue, busy, done, psum_prefetch_addr, psum_vld, psum_last_rnd, psum_wr_addr
  );

endinterface

`default_nettype wire

// File: rtl/conv_sa_flag_dly.sv
// ============================================================================
// Module      : conv_sa_flag_dly
// Description : Multi-stage {vld, last, addr} delay line; every stage is
//               exposed for the read-after-write hazard compare.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module conv_sa_flag_dly #(
  parameter int AW  = conv_sa_pkg::SLOT_AW,
  parameter int LAT = conv_sa_pkg::PF2WR_LAT
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  in_vld,
  input  wire logic                  in_last,
  input  wire logic [AW-1:0]         in_addr,
  input  wire logic                  clr_en,
  input  wire logic [AW-1:0]         clr_addr,
  output logic      [LAT-1:0]        stg_vld,
  output logic      [LAT-1:0]        stg_last,
  output logic      [LAT-1:0][AW-1:0] stg_addr
);

  logic [LAT-1:0]         w_prev_vld;
  logic [LAT-1:0]         w_prev_last;
  logic [LAT-1:0][AW-1:0] w_prev_addr;

  assign w_prev_vld  = {stg_vld[LAT-2:0],  in_vld};
  assign w_prev_last = {stg_last[LAT-2:0], in_last};
  assign w_prev_addr = {stg_addr[LAT-2:0], in_addr};

  genvar g;
  generate
    for (g = 0; g < LAT; g++) begin : g_stage
      logic          r_vld;
      logic          r_last;
      logic [AW-1:0] r_addr;

      // A clear write lands directly in the output stage so it is visible
      // on the first cycle after reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld  <= 1'b0;
          r_last <= 1'b0;
          r_addr <= '0;
        end else if (clr_en) begin
          r_vld  <= (g == LAT - 1);
          r_last <= (g == LAT - 1);
          r_addr <= (g == LAT - 1) ? clr_addr : '0;
        end else begin
          r_vld  <= w_prev_vld[g];
          r_last <= w_prev_last[g];
          r_addr <= w_prev_addr[g];
        end
      end

      assign stg_vld[g]  = r_vld;
      assign stg_last[g] = r_last;
      assign stg_addr[g] = r_addr;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/conv_sa_psum_seq.sv
// ============================================================================
// Module      : conv_sa_psum_seq
// Description : Head-of-chain psum flag sequencer: slot/round ordering,
//               RAW hazard bubbles, feeder pacing and power-up slot clear.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module conv_sa_psum_seq #(
  parameter int SLOT_AW = conv_sa_pkg::SLOT_AW,
  parameter int RND_W   = 16
) (
  input wire logic           clk,
  input wire logic           rst,
  conv_sa_psum_seq_if.master bus
);

  import conv_sa_pkg::*;

  localparam int               c_lat          = PF2WR_LAT;
  localparam logic [SLOT_AW:0] c_n_slot_max   = (SLOT_AW + 1)'(2 ** SLOT_AW);

  seq_state_t r_state;
  seq_state_t w_state_nxt;

  logic [SLOT_AW:0]   r_init_cnt;
  logic [SLOT_AW-1:0] r_slot;
  logic [SLOT_AW-1:0] r_last_slot;
  logic [RND_W-1:0]   r_rnd;
  logic [RND_W-1:0]   r_last_rnd;
  logic               r_busy;
  logic               r_done;

  logic               w_issue;
  logic               w_hazard;
  logic               w_tag_last;
  logic               w_final;
  logic               w_init_wr;
  logic               w_zero_cfg;
  logic               w_launch;
  logic               w_done_nxt;
  logic [SLOT_AW:0]   w_n_slot;

  logic [c_lat-1:0]              w_stg_vld;
  logic [c_lat-1:0]              w_stg_last;
  logic [c_lat-1:0][SLOT_AW-1:0] w_stg_addr;

  assign w_n_slot   = (bus.cfg_n_slot > c_n_slot_max) ? c_n_slot_max : bus.cfg_n_slot;
  assign w_zero_cfg = (bus.cfg_n_slot == '0) || (bus.cfg_n_rnd == '0);
  assign w_launch   = (r_state == ST_IDLE) && bus.start && !w_zero_cfg;
  assign w_tag_last = (r_rnd == r_last_rnd);
  assign w_final    = w_tag_last && (r_slot == r_last_slot);

  // A slot in flight anywhere in the delay line has not been written back yet.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < c_lat; i++) begin
      if (w_stg_vld[i] && (w_stg_addr[i] == r_slot)) begin
        w_hazard = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_done_nxt  = 1'b0;
    w_init_wr   = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (r_init_cnt == c_n_slot_max) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_init_wr = 1'b1;
        end
      end
      ST_IDLE: begin
        if (bus.start) begin
          if (w_zero_cfg) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        w_issue = bus.src_rdy && !w_hazard;
        if (w_issue && w_final) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Only the output stage still holds a flag: it leaves on this edge.
        if (w_stg_vld[c_lat-2:0] == '0) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_init_cnt  <= '0;
      r_slot      <= '0;
      r_last_slot <= '0;
      r_rnd       <= '0;
      r_last_rnd  <= '0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= w_done_nxt;
      if (w_init_wr) begin
        r_init_cnt <= r_init_cnt + 1'b1;
      end
      if (w_launch) begin
        r_slot      <= '0;
        r_rnd       <= '0;
        r_last_slot <= SLOT_AW'(w_n_slot - 1'b1);
        r_last_rnd  <= bus.cfg_n_rnd - 1'b1;
      end else if (w_issue) begin
        if (r_slot == r_last_slot) begin
          r_slot <= '0;
          r_rnd  <= r_rnd + 1'b1;
        end else begin
          r_slot <= r_slot + 1'b1;
        end
      end
    end
  end

  conv_sa_flag_dly #(
    .AW  (SLOT_AW),
    .LAT (c_lat)
  ) u_flag_dly (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (w_issue),
    .in_last  (w_issue && w_tag_last),
    .in_addr  (r_slot),
    .clr_en   (w_init_wr),
    .clr_addr (r_init_cnt[SLOT_AW-1:0]),
    .stg_vld  (w_stg_vld),
    .stg_last (w_stg_last),
    .stg_addr (w_stg_addr)
  );

  assign bus.issue              = w_issue;
  assign bus.busy               = r_busy;
  assign bus.done               = r_done;
  assign bus.psum_prefetch_addr = r_slot;
  assign bus.psum_vld           = w_stg_vld[c_lat-1];
  assign bus.psum_last_rnd      = w_stg_last[c_lat-1];
  assign bus.psum_wr_addr       = w_stg_addr[c_lat-1];

endmodule

`default_nettype wire

// File: tb/tb_conv_sa_psum_seq.sv
// ============================================================================
// Module      : tb_conv_sa_psum_seq
// Description : Self-checking bench: timestamp-based reference of the psum
//               flag protocol plus directed literal timing expectations.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_conv_sa_psum_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_sa_psum_seq_if #(.SLOT_AW(3), .RND_W(16)) bus ();

  conv_sa_psum_seq #(.SLOT_AW(3), .RND_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_done_cyc = -1;
  int rdy_mode = 0;

  // Reference: a tile is a list of (slot, round) beats; each beat may issue
  // once its slot was last prefetched >= 3 cycles ago; flags land at +2.
  int m_n = 0, m_idx = 0, m_ns = 1, m_nr = 1, m_run_from = 0;
  int m_busy_end = 1 << 30, m_done_at = -1;
  int m_last_pf [8];
  logic [3:0] ev [int];

  int act_issue_q[$], act_last_q[$], act_done_q[$];
  int act_vld_cnt = 0;

  int cur, slot, rnd;
  logic e_issue, e_busy, e_done, e_vld;
  logic [3:0] e_ent;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    cur = cyc;
    if (bus.issue === 1'b1) act_issue_q.push_back(cur);
    if (bus.psum_vld === 1'b1) begin
      act_vld_cnt++;
      if (bus.psum_last_rnd === 1'b1) act_last_q.push_back(cur);
    end
    if (bus.done === 1'b1) begin
      act_done_q.push_back(cur);
      last_done_cyc = cur;
    end

    if (rst) begin
      chk("rst_issue", 32'(bus.issue), 0);
      chk("rst_busy", 32'(bus.busy), 1);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_vld", 32'(bus.psum_vld), 0);
      chk("rst_last", 32'(bus.psum_last_rnd), 0);
      chk("rst_wr_addr", 32'(bus.psum_wr_addr), 0);
      chk("rst_pf_addr", 32'(bus.psum_prefetch_addr), 0);
      ev.delete();
      for (int k = 0; k < 8; k++) ev[cur + 2 + k] = {1'b1, 3'(k)};
      m_busy_end = cur + 9;
      m_done_at  = -1;
      m_n = 0;
      m_idx = 0;
    end else begin
      e_issue = 1'b0;
      slot = 0;
      rnd = 0;
      if (m_idx < m_n && cur >= m_run_from) begin
        slot = m_idx % m_ns;
        rnd  = m_idx / m_ns;
        e_issue = bus.src_rdy && (cur - m_last_pf[slot] >= 3);
      end
      e_busy = (cur <= m_busy_end);
      e_done = (cur == m_done_at);
      e_vld  = ev.exists(cur);
      e_ent  = e_vld ? ev[cur] : 4'd0;

      chk("issue", 32'(bus.issue), 32'(e_issue));
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("done", 32'(bus.done), 32'(e_done));
      chk("psum_vld", 32'(bus.psum_vld), 32'(e_vld));
      chk("psum_last_rnd", 32'(bus.psum_last_rnd), 32'(e_ent[3]));
      if (e_vld) chk("psum_wr_addr", 32'(bus.psum_wr_addr), 32'(e_ent[2:0]));
      if (e_issue) chk("prefetch_addr", 32'(bus.psum_prefetch_addr), 32'(slot));

      if (e_issue) begin
        ev[cur + 2] = {(rnd == m_nr - 1), 3'(slot)};
        m_last_pf[slot] = cur;
        m_idx++;
        if (m_idx == m_n) begin
          m_done_at  = cur + 3;
          m_busy_end = cur + 2;
        end
      end

      if (bus.start && !e_busy) begin
        m_ns = (bus.cfg_n_slot > 4'd8) ? 8 : int'(bus.cfg_n_slot);
        m_nr = int'(bus.cfg_n_rnd);
        if (m_ns == 0 || m_nr == 0) begin
          m_done_at = cur + 1;
        end else begin
          m_n = m_ns * m_nr;
          m_idx = 0;
          m_run_from = cur + 1;
          m_busy_end = 1 << 30;
          foreach (m_last_pf[i]) m_last_pf[i] = -100;
        end
      end
      if (e_vld) ev.delete(cur);
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    case (rdy_mode)
      0:       bus.src_rdy = 1'b1;
      1:       bus.src_rdy = (cyc % 2 == 0);
      default: bus.src_rdy = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic clear_obs();
    act_issue_q.delete();
    act_last_q.delete();
    act_done_q.delete();
    act_vld_cnt = 0;
  endtask

  task automatic launch(input int ns, input int nr, output int t);
    tick();
    bus.start      = 1'b1;
    bus.cfg_n_slot = 4'(ns);
    bus.cfg_n_rnd  = 16'(nr);
    t = cyc;
  endtask

  task automatic wait_done(input int t);
    int k = 0;
    while (last_done_cyc <= t && k < 600) begin
      tick();
      k++;
    end
    if (last_done_cyc <= t) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout start=%0d got=no_done want=done", t);
    end
  endtask

  int t;

  initial begin
    bus.start = 1'b0;
    bus.cfg_n_slot = '0;
    bus.cfg_n_rnd = '0;
    bus.src_rdy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    clear_obs();
    repeat (12) tick();
    chk("init_vld_cycles", act_vld_cnt, 8);
    chk("init_no_done", act_done_q.size(), 0);

    // 4 slots x 3 rounds at full rate
    rdy_mode = 0;
    clear_obs();
    launch(4, 3, t);
    wait_done(t);
    chk("A_issue_cnt", act_issue_q.size(), 12);
    for (int i = 0; i < 12; i++)
      if (i < act_issue_q.size()) chk("A_issue_cyc", act_issue_q[i], t + 1 + i);
    chk("A_last_cnt", act_last_q.size(), 4);
    if (act_last_q.size() == 4) begin
      chk("A_last_first", act_last_q[0], t + 11);
      chk("A_last_final", act_last_q[3], t + 14);
    end
    chk("A_done_cyc", last_done_cyc, t + 15);

    // single slot: two bubbles per issue
    clear_obs();
    launch(1, 4, t);
    wait_done(t);
    chk("B_issue_cnt", act_issue_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < act_issue_q.size()) chk("B_issue_cyc", act_issue_q[i], t + 1 + 3 * i);
    chk("B_done_cyc", last_done_cyc, t + 13);

    // feeder stalls every other cycle
    rdy_mode = 1;
    clear_obs();
    launch(8, 2, t);
    wait_done(t);
    chk("C_issue_cnt", act_issue_q.size(), 16);

    // zero rounds
    rdy_mode = 0;
    clear_obs();
    launch(5, 0, t);
    wait_done(t);
    chk("Z_done_cyc", last_done_cyc, t + 1);
    chk("Z_issue_cnt", act_issue_q.size(), 0);
    chk("Z_vld_cnt", act_vld_cnt, 0);

    // oversize slot count clamps to 8; a start during RUN is ignored
    clear_obs();
    launch(12, 2, t);
    tick();
    tick();
    bus.start = 1'b1;
    bus.cfg_n_slot = 4'd1;
    bus.cfg_n_rnd = 16'd1;
    wait_done(t);
    chk("K_issue_cnt", act_issue_q.size(), 16);
    chk("K_done_cyc", last_done_cyc, t + 19);

    // randomized tiles
    rdy_mode = 2;
    for (int i = 0; i < 30; i++) begin
      launch($urandom_range(0, 15), $urandom_range(0, 5), t);
      wait_done(t);
    end

    // reset in the middle of a tile, then a fresh tile
    rdy_mode = 0;
    launch(5, 4, t);
    repeat (6) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (12) tick();
    clear_obs();
    launch(3, 2, t);
    wait_done(t);
    chk("R_issue_cnt", act_issue_q.size(), 6);
    chk("R_done_cyc", last_done_cyc, t + 9);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d got=running want=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
